// File: rtl/cclk_driver.sv
// cclk_driver: drives a readiness line toward a peer. The line is held low
// through a startup holdoff, raised only while the local side enables it, and
// every fall is followed by a guaranteed minimum low pulse so the peer always
// sees a clean deassert / re-qualify sequence. `announced` reports that the
// line has been high long enough for the peer to have qualified it.
//
// Handshake: there is no valid/ready pair here. `enable` is a level sampled
// on every rising edge and is honoured only in IDLE and HIGH. `drop` is a
// request sampled on every rising edge and is honoured only in HIGH. All
// outputs are registered and decoded from the next state, so each output
// value lines up exactly with the state it belongs to.
module cclk_driver #(
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int MIN_LOW_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       drop,
  output logic       cclk,
  output logic       announced,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int MAX_AB = (HOLDOFF_CYCLES > SETTLE_CYCLES) ? HOLDOFF_CYCLES : SETTLE_CYCLES;
  localparam int MAX_C  = (MAX_AB > MIN_LOW_CYCLES) ? MAX_AB : MIN_LOW_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  // Terminal counts. The counter is cleared on entry to each state, so the
  // last cycle of an N-cycle state is the one where ctr == N-1.
  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] LOW_TC    = CW'(MIN_LOW_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_HIGH    = 2'd2,
    ST_LOWHOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic          cclk_d, announced_d, busy_d;

  assign dbg_state = state_q;

  // State and counter register; reset returns to the start of the holdoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STARTUP;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next-state and counter update; the counter clears on every state change
  // and saturates at the settle count while HIGH so it never wraps.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      ST_STARTUP: begin
        if (ctr_q == HOLD_TC) begin
          state_d = ST_IDLE;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        ctr_d = '0;
        if (enable) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // Drop and enable-low together still mean a single LOWHOLD entry.
        if (drop || !enable) begin
          state_d = ST_LOWHOLD;
          ctr_d   = '0;
        end else if (ctr_q != SETTLE_TC) begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_LOWHOLD: begin
        // drop is deliberately ignored here: the pulse is neither extended
        // nor restarted.
        if (ctr_q == LOW_TC) begin
          state_d = ST_IDLE;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        ctr_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs coincide
  // with the state they describe.
  always_comb begin
    cclk_d      = (state_d == ST_HIGH);
    announced_d = (state_d == ST_HIGH) && (ctr_d == SETTLE_TC);
    busy_d      = (state_d == ST_STARTUP) || (state_d == ST_LOWHOLD);
  end

  // Output registers; reset drives the line low and reports busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cclk      <= 1'b0;
      announced <= 1'b0;
      busy      <= 1'b1;
    end else begin
      cclk      <= cclk_d;
      announced <= announced_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_cclk_driver.sv
// Directed bench for cclk_driver with HOLDOFF=8, SETTLE=4, MIN_LOW=5.
// Each step drives inputs, pushes the hand-derived expected
// {cclk, announced, busy} onto a queue, advances one rising edge and pops
// the expectation against the DUT outputs sampled 1 time unit later.
module tb_cclk_driver;

  localparam int HOLD = 8;
  localparam int SET  = 4;
  localparam int LOW  = 5;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       drop;
  logic       cclk;
  logic       announced;
  logic       busy;
  logic [1:0] dbg_state;

  logic [2:0] exp_q[$];
  int         n_vec;
  int         n_err;

  cclk_driver #(
    .HOLDOFF_CYCLES(HOLD),
    .SETTLE_CYCLES (SET),
    .MIN_LOW_CYCLES(LOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .drop     (drop),
    .cclk     (cclk),
    .announced(announced),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check(input string tag);
    logic [2:0] exp_v;
    logic [2:0] obs_v;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, {cclk, announced, busy});
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = {cclk, announced, busy};
      n_vec++;
      assert (obs_v === exp_v)
      else begin
        n_err++;
        $error("FAIL %s: observed {cclk,ann,busy}=%b expected %b", tag, obs_v, exp_v);
      end
    end
  endtask

  // One clock edge with the given inputs and the expected outputs after it.
  task automatic step(input logic en, input logic dr,
                      input logic e_c, input logic e_a, input logic e_b,
                      input string tag);
    enable = en;
    drop   = dr;
    exp_q.push_back({e_c, e_a, e_b});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // n identical steps.
  task automatic run(input int n, input logic en, input logic dr,
                     input logic e_c, input logic e_a, input logic e_b,
                     input string tag);
    for (int i = 0; i < n; i++) step(en, dr, e_c, e_a, e_b, tag);
  endtask

  // Reset release followed by the scenario-1 timing. The holdoff cycles
  // toggle drop when drop_in_startup is set, which must change nothing.
  task automatic startup_seq(input logic drop_in_startup, input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    // edges 1..7: STARTUP
    for (int i = 1; i < HOLD; i++)
      step(1'b1, drop_in_startup & i[0], 1'b0, 1'b0, 1'b1, {tag, "_startup"});
    // edge 8: terminal count, IDLE
    step(1'b1, drop_in_startup, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
    // edge 9: HIGH, edges 10..12 still settling
    run(SET, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {tag, "_settle"});
    // edge 13: announced
    run(2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, {tag, "_announced"});
  endtask

  // Directed sequence
  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    drop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(3'b001);
    check("reset_values");

    // Scenario 1: reset release with enable high.
    startup_seq(1'b0, "s1");

    // Scenario 2: one-cycle drop in steady HIGH.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "s2_drop_edge");
    run(LOW - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "s2_lowhold");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "s2_idle");
    run(SET, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "s2_settle");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "s2_announced");

    // Scenario 3: enable falls in HIGH; line waits in IDLE for enable.
    run(LOW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "s3_lowhold");
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s3_idle_wait");
    run(SET, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "s3_settle");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "s3_announced");

    // Scenario 4: drop and enable-low together, then drop held through
    // LOWHOLD and IDLE must neither stretch nor restart anything.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "s4_both_edge");
    run(LOW - 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "s4_lowhold_drop");
    run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s4_idle_drop");
    run(SET, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "s4_settle");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "s4_announced");

    // Scenario 5: asynchronous reset mid-HIGH, outputs clear before the
    // next edge; then startup repeats, with drop pulses in the holdoff.
    rst_n = 1'b0;
    #1;
    exp_q.push_back(3'b001);
    check("s5_async_reset");
    startup_seq(1'b1, "s5");

    // Scenario 6: single-sample enable in IDLE gives a one-cycle high.
    run(LOW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "s6_lowhold_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s6_idle_a");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "s6_one_high");
    run(LOW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "s6_lowhold_b");
    run(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s6_idle_b");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cclk_driver.md
# cclk_driver

Drives a cclk-style readiness line toward a peer device, which qualifies the line by requiring it to stay high for a run of cycles and drops its own ready whenever the line falls. This block holds the line low through a startup holdoff and raises it only when the local side enables it. It enforces a guaranteed minimum low pulse on every fall, so the peer always sees a clean deassert/re-qualify sequence. It reports locally when the line has been high long enough that the peer has qualified it.

## Interface
- `HOLDOFF_CYCLES`, default 1024: cycles the line is held low after reset release; must be ≥1.
- `SETTLE_CYCLES`, default 1024: cycles the line must stay high before `announced` asserts; must be ≥1.
- `MIN_LOW_CYCLES`, default 1024: minimum low-pulse length after any fall; must be ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: local side wants the line high; level, sampled every cycle.
- `drop` in 1: request a forced low pulse (re-announce); meaningful only in HIGH.
- `cclk` out 1: registered readiness line to the peer.
- `announced` out 1: registered; line has been high ≥ `SETTLE_CYCLES` cycles.
- `busy` out 1: registered; high in STARTUP or LOWHOLD, where `enable` is not yet honoured.

## Operation
- One counter `ctr`, width `$clog2(max(HOLDOFF_CYCLES, SETTLE_CYCLES, MIN_LOW_CYCLES)+1)`.
- `ctr` is cleared on every state change.
- `ctr` never wraps: it saturates at `SETTLE_CYCLES` in HIGH and is bounded by the terminal count elsewhere.
- States and transitions:
  - **STARTUP**: `cclk`=0, `busy`=1; `ctr` counts up. When `ctr == HOLDOFF_CYCLES-1` → IDLE.
  - **IDLE**: `cclk`=0, `busy`=0. When `enable`=1 → HIGH.
  - **HIGH**: `cclk`=1; `ctr` increments, saturating at `SETTLE_CYCLES`; `announced`=1 when `ctr == SETTLE_CYCLES`. When `drop`=1 or `enable`=0 → LOWHOLD. Both conditions together give a single LOWHOLD entry.
  - **LOWHOLD**: `cclk`=0, `announced`=0, `busy`=1; `ctr` counts up. When `ctr == MIN_LOW_CYCLES-1` → IDLE.
- `drop` is ignored in STARTUP, IDLE and LOWHOLD; it neither extends nor restarts LOWHOLD.
- `enable` is ignored in STARTUP and LOWHOLD. If it is high on IDLE entry, HIGH follows on the next edge.
- Outputs are decoded from next-state and registered, so each output value coincides exactly with the state it belongs to. There is no combinational path from input to output.
- Reset (`rst_n`=0, any time, including mid-HIGH or mid-LOWHOLD):
  - state → STARTUP, `ctr` → 0.
  - `cclk`, `announced` → 0 immediately; `busy` → 1.

## Timing
- Reset values: `cclk`=0, `announced`=0, `busy`=1.
- Edge 1 is the first rising edge after `rst_n` deasserts.
- STARTUP occupies edges 1..`HOLDOFF_CYCLES`. With `enable` held at 1, IDLE lasts one cycle and `cclk` first reads 1 after edge `HOLDOFF_CYCLES+1`.
- `enable` sampled 1 in IDLE at edge k → `cclk`=1 after edge k.
- `announced`=1 after edge k+`SETTLE_CYCLES` if HIGH holds throughout.
- `drop` or `enable`=0 sampled at edge m in HIGH → `cclk` and `announced` read 0 after edge m.
- LOWHOLD lasts exactly `MIN_LOW_CYCLES` cycles, then at least one IDLE cycle follows. Minimum low time is therefore `MIN_LOW_CYCLES`+1 cycles.
- Minimum high time is 1 cycle: `enable` high for a single IDLE sample, then low. `announced` never asserts in that case.

## Test plan
All scenarios use `HOLDOFF_CYCLES`=8, `SETTLE_CYCLES`=4, `MIN_LOW_CYCLES`=5.
1. Reset release with `enable`=1 → `cclk`=0 through edge 8; `cclk`=1 after edge 9; `announced`=1 after edge 13; `busy`=1 through edge 8, then 0.
2. In steady HIGH, 1-cycle `drop` at edge m → `cclk`/`announced`=0 after edge m; `busy`=1 for edges m..m+4; `cclk`=1 again after edge m+6; `announced`=1 after edge m+10.
3. `enable` falls at edge m in HIGH → LOWHOLD for 5 cycles; `cclk` stays 0 in IDLE until `enable` returns, then rises the cycle after `enable` is sampled high.
4. `drop` pulses during STARTUP, IDLE and mid-LOWHOLD → no effect: STARTUP still 8 cycles, LOWHOLD still 5 cycles, `cclk` unchanged.
5. `rst_n` pulled low mid-HIGH with `announced`=1 → `cclk`=0, `announced`=0, `busy`=1 before the next edge; after release, scenario 1 timing repeats exactly.
6. `enable` high for a single sample in IDLE → `cclk`=1 for exactly one cycle; `announced` stays 0; 5-cycle LOWHOLD follows.
